// File: rtl/morse_rx.sv
// Morse receive front end: debounces the key, times marks/spaces in dot units and packs symbols into a 6-bit code.
// Latency: key release to data_valid is DEBOUNCE_CYCLES + 2*UNIT_CYCLES + 2 clocks (+2 with MORSE_RX_SYNC_EN).
// Backpressure: none; every data_valid pulse must be taken by the downstream decoder.
//
// Ports:
//   clk_100Mhz  in   system clock
//   reset       in   asynchronous active-low reset
//   key_in      in   raw morse key, 1 = pressed
//   data_valid  out  one-cycle pulse, char_data/char_index valid
//   char_index  out  1 = first character of a new word
//   char_data   out  leading-1 sentinel followed by symbols (dot=0, dash=1); 6'h00 = error
//
// Build option: define MORSE_RX_SYNC_EN to place a 2-flop synchronizer on key_in.
// Without it key_in is used directly and must be driven synchronously to clk_100Mhz.

module morse_rx #(
   parameter int UNIT_CYCLES     = 6_000_000,
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic       clk_100Mhz,
   input  logic       reset,
   input  logic       key_in,
   output logic       data_valid,
   output logic       char_index,
   output logic [5:0] char_data
);

   localparam int TW = $clog2(5*UNIT_CYCLES + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [TW-1:0] T_DASH  = TW'(2*UNIT_CYCLES);
   localparam logic [TW-1:0] T_SAT   = TW'(5*UNIT_CYCLES);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MARK  = 2'd1,
      SPACE = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic            key_s;
   logic            key_db, key_db_q;
   logic [DW-1:0]   db_cnt;
   logic [TW-1:0]   tcnt;
   logic [5:0]      code;
   logic [2:0]      sym_cnt;
   logic            ovf;
   logic            word_pend;
   logic            emit;
   logic            take_sym;
   logic            to_idle;
   logic            symbol;

   // ------------------------------------------------------------------
   // Key input conditioning
   // ------------------------------------------------------------------
`ifdef MORSE_RX_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk_100Mhz or negedge reset) begin
      if (!reset) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], key_in};
      end
   end

   assign key_s = sync_q[1];
`else
   assign key_s = key_in;
`endif

   // key_db only moves once key_s has disagreed with it for DEBOUNCE_CYCLES
   // consecutive clocks; any agreement in between restarts the count.
   always_ff @(posedge clk_100Mhz or negedge reset) begin
      if (!reset) begin
         key_db   <= 1'b0;
         key_db_q <= 1'b0;
         db_cnt   <= '0;
      end else begin
         key_db_q <= key_db;
         if (key_s == key_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            key_db <= key_s;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Mark/space timer: restarts on every debounced edge, saturates so a
   // long mark or idle period never wraps back into a short one.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_100Mhz or negedge reset) begin
      if (!reset) begin
         tcnt <= '0;
      end else if (key_db ^ key_db_q) begin
         tcnt <= '0;
      end else if (tcnt != T_SAT) begin
         tcnt <= tcnt + TW'(1);
      end
   end

   assign symbol = (tcnt >= T_DASH);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk_100Mhz or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Presses are tested on the key_db level rather than a one-cycle edge so
   // a press that lands on the SPACE emit cycle is still picked up in GAP on
   // the next cycle.
   always_comb begin
      state_nxt = state;
      emit      = 1'b0;
      take_sym  = 1'b0;
      to_idle   = 1'b0;
      case (state)
         IDLE: begin
            if (key_db) state_nxt = MARK;
         end
         MARK: begin
            if (!key_db) begin
               take_sym  = 1'b1;
               state_nxt = SPACE;
            end
         end
         SPACE: begin
            if (tcnt == T_DASH) begin
               emit      = 1'b1;
               state_nxt = GAP;
            end else if (key_db) begin
               state_nxt = MARK;
            end
         end
         GAP: begin
            if (key_db) begin
               state_nxt = MARK;
            end else if (tcnt == T_SAT) begin
               to_idle   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Character assembly and output register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_100Mhz or negedge reset) begin
      if (!reset) begin
         code       <= 6'b000001;
         sym_cnt    <= 3'd0;
         ovf        <= 1'b0;
         word_pend  <= 1'b1;
         data_valid <= 1'b0;
         char_data  <= 6'h00;
         char_index <= 1'b0;
      end else begin
         data_valid <= emit;
         if (emit) begin
            char_data  <= ovf ? 6'h00 : code;
            char_index <= word_pend;
            word_pend  <= 1'b0;
            code       <= 6'b000001;
            sym_cnt    <= 3'd0;
            ovf        <= 1'b0;
         end else if (take_sym) begin
            // Only five symbols fit behind the sentinel; a sixth poisons
            // the whole character instead of truncating it.
            if (sym_cnt < 3'd5) begin
               code    <= {code[4:0], symbol};
               sym_cnt <= sym_cnt + 3'd1;
            end else begin
               ovf <= 1'b1;
            end
         end
         if (to_idle) begin
            word_pend <= 1'b1;
         end
      end
   end

endmodule
